// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit for the multicycle MIPS core.
// Owns PC and IR, issues one instruction-memory read per IRWrite pulse over a
// valid/ready request + rvalid response handshake, and exposes the decoded IR
// fields. All outputs come from registers or are decoded from the FSM state.
module instr_fetch_unit #(
  parameter int          N        = 32,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         IRWrite,
  input  logic         PCWrite,
  input  logic [N-1:0] pc_next,
  output logic         mem_req_valid,
  input  logic         mem_req_ready,
  output logic [N-1:0] mem_addr,
  input  logic         mem_rvalid,
  input  logic [N-1:0] mem_rdata,
  output logic [N-1:0] pc,
  output logic [N-1:0] ir,
  output logic [5:0]   Op_code,
  output logic [5:0]   Funct,
  output logic [4:0]   rs,
  output logic [4:0]   rt,
  output logic [4:0]   rd,
  output logic [4:0]   shamt,
  output logic [15:0]  imm,
  output logic         instr_valid,
  output logic         fetch_busy,
  output logic         fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [N-1:0] fetch_addr;
  logic         pc_aligned;
  logic         start_fetch;
  logic         resp_take;

  // A fetch only starts from IDLE on a word-aligned PC.
  assign pc_aligned  = (pc[1:0] == 2'b00);
  assign start_fetch = (state == S_IDLE) && IRWrite && pc_aligned;
  // Responses are only consumed while waiting; stray rvalid elsewhere is dropped.
  assign resp_take   = (state == S_WAIT) && mem_rvalid;

  // State register; reset abandons any in-flight fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> REQ on aligned IRWrite, REQ -> WAIT on accept, WAIT -> IDLE on rvalid.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_fetch)   state_nxt = S_REQ;
      S_REQ:  if (mem_req_ready) state_nxt = S_WAIT;
      S_WAIT: if (mem_rvalid)    state_nxt = S_IDLE;
      default:                   state_nxt = S_IDLE;
    endcase
  end

  // Handshake and busy flags decoded purely from state, so no input reaches an output combinationally.
  always_comb begin
    mem_req_valid = (state == S_REQ);
    fetch_busy    = (state != S_IDLE);
  end

  // PC, latched fetch address, IR and status flags.
  // fetch_addr is captured at fetch start so a concurrent PCWrite never disturbs
  // the address presented to memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      fetch_addr  <= '0;
      ir          <= '0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      if (PCWrite) begin
        pc <= pc_next;
      end
      if (start_fetch) begin
        fetch_addr  <= pc;
        instr_valid <= 1'b0;
      end
      // Misaligned request, or a new request while one is still outstanding.
      if (IRWrite && ((state != S_IDLE) || !pc_aligned)) begin
        fetch_err <= 1'b1;
      end
      if (resp_take) begin
        ir          <= mem_rdata;
        instr_valid <= 1'b1;
      end
    end
  end

  assign mem_addr = fetch_addr;

  // Instruction field decode: plain slices of IR.
  assign Op_code = ir[31:26];
  assign rs      = ir[25:21];
  assign rt      = ir[20:16];
  assign rd      = ir[15:11];
  assign shamt   = ir[10:6];
  assign Funct   = ir[5:0];
  assign imm     = ir[15:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed vectors with a queue-based
// scoreboard; a negedge monitor checks every accepted request address and
// every completed instruction against the expected queues.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        IRWrite;
  logic        PCWrite;
  logic [31:0] pc_next;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [5:0]  Op_code;
  logic [5:0]  Funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic        instr_valid;
  logic        fetch_busy;
  logic        fetch_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_ir_q[$];
  logic        iv_prev = 1'b0;

  instr_fetch_unit #(.N(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .IRWrite(IRWrite), .PCWrite(PCWrite), .pc_next(pc_next),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .pc(pc), .ir(ir),
    .Op_code(Op_code), .Funct(Funct), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm),
    .instr_valid(instr_valid), .fetch_busy(fetch_busy), .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard comparison on request acceptance and on fetch completion.
  always @(negedge clk) begin
    if (rst && mem_req_valid && mem_req_ready) begin
      if (exp_addr_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_req: got addr %h expected no request", mem_addr);
      end else begin
        chk("req_addr", mem_addr, exp_addr_q.pop_front());
      end
    end
    if (instr_valid && !iv_prev) begin
      if (exp_ir_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_instr: got ir %h expected no completion", ir);
      end else begin
        chk("ir_data", ir, exp_ir_q.pop_front());
      end
    end
    iv_prev = instr_valid;
  end

  // One complete fetch: IRWrite (optionally with PCWrite), 'delay' cycles of ready low, then a 1-cycle memory.
  task automatic fetch(input int delay, input logic [31:0] addr, input logic [31:0] data,
                       input bit pcw, input logic [31:0] pcn);
    exp_addr_q.push_back(addr);
    exp_ir_q.push_back(data);
    IRWrite = 1'b1; PCWrite = pcw; pc_next = pcn;
    tick();
    IRWrite = 1'b0; PCWrite = 1'b0;
    for (int i = 0; i < delay; i++) begin
      chk("stall_valid", {31'b0, mem_req_valid}, 32'd1);
      chk("stall_addr", mem_addr, addr);
      chk("stall_busy", {31'b0, fetch_busy}, 32'd1);
      tick();
    end
    chk("req_valid", {31'b0, mem_req_valid}, 32'd1);
    chk("req_addr_hold", mem_addr, addr);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("wait_busy", {31'b0, fetch_busy}, 32'd1);
    chk("wait_no_req", {31'b0, mem_req_valid}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = data;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    chk("done_valid", {31'b0, instr_valid}, 32'd1);
    chk("done_ir", ir, data);
    chk("done_idle", {31'b0, fetch_busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; IRWrite = 1'b0; PCWrite = 1'b0; pc_next = 32'h0;
    mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    tick(); tick();
    // Reset state
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_reqv", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_iv", {31'b0, instr_valid}, 32'd0);
    chk("rst_err", {31'b0, fetch_err}, 32'd0);
    chk("rst_busy", {31'b0, fetch_busy}, 32'd0);
    rst = 1'b1;
    tick();

    // Basic fetch at address 0 and field decode
    fetch(0, 32'h0, 32'h012A4020, 1'b0, 32'h0);
    chk("op_code", {26'b0, Op_code}, 32'h0);
    chk("funct", {26'b0, Funct}, 32'h20);
    chk("rs", {27'b0, rs}, 32'd9);
    chk("rt", {27'b0, rt}, 32'd10);
    chk("rd", {27'b0, rd}, 32'd8);
    chk("shamt", {27'b0, shamt}, 32'd0);
    chk("imm", {16'b0, imm}, 32'h4020);

    // Simultaneous IRWrite and PCWrite: fetch from old pc, PC takes pc_next
    fetch(0, 32'h0, 32'h8C880004, 1'b1, 32'h4);
    chk("pcw_pc", pc, 32'h4);
    chk("pcw_op", {26'b0, Op_code}, 32'h23);

    // Next fetch uses address 4, with ready held low for 3 cycles
    fetch(3, 32'h4, 32'hAC0A0010, 1'b0, 32'h0);
    chk("stall_err", {31'b0, fetch_err}, 32'd0);

    // Stray rvalid in IDLE is ignored
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    chk("stray_ir", ir, 32'hAC0A0010);
    chk("stray_busy", {31'b0, fetch_busy}, 32'd0);

    // IRWrite during WAIT flags an error; original fetch still completes
    exp_addr_q.push_back(32'h4);
    exp_ir_q.push_back(32'h3C011234);
    IRWrite = 1'b1;
    tick();
    IRWrite = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; IRWrite = 1'b1;
    tick();
    IRWrite = 1'b0;
    chk("busy_irw_err", {31'b0, fetch_err}, 32'd1);
    chk("busy_irw_wait", {31'b0, fetch_busy}, 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'h3C011234;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    chk("busy_irw_ir", ir, 32'h3C011234);
    chk("busy_irw_idle", {31'b0, fetch_busy}, 32'd0);
    tick();
    chk("busy_irw_single", {31'b0, mem_req_valid}, 32'd0);

    // Reset during WAIT; late rvalid after release is ignored
    exp_addr_q.push_back(32'h4);
    IRWrite = 1'b1;
    tick();
    IRWrite = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("pre_rst_wait", {31'b0, fetch_busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_ir", ir, 32'h0);
    chk("mid_rst_busy", {31'b0, fetch_busy}, 32'd0);
    chk("mid_rst_err", {31'b0, fetch_err}, 32'd0);
    chk("mid_rst_iv", {31'b0, instr_valid}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    chk("late_rv_ir", ir, 32'h0);
    chk("late_rv_iv", {31'b0, instr_valid}, 32'd0);
    chk("late_rv_busy", {31'b0, fetch_busy}, 32'd0);

    // Misaligned PC: no request, sticky error, instr_valid unchanged
    fetch(0, 32'h0, 32'h00000000, 1'b0, 32'h0);
    PCWrite = 1'b1; pc_next = 32'h2;
    tick();
    PCWrite = 1'b0;
    chk("mis_pc", pc, 32'h2);
    IRWrite = 1'b1;
    tick();
    IRWrite = 1'b0;
    chk("mis_reqv", {31'b0, mem_req_valid}, 32'd0);
    chk("mis_busy", {31'b0, fetch_busy}, 32'd0);
    chk("mis_err", {31'b0, fetch_err}, 32'd1);
    chk("mis_iv", {31'b0, instr_valid}, 32'd1);
    tick();
    chk("mis_err_sticky", {31'b0, fetch_err}, 32'd1);

    // PC wraps modulo 2^32 (plain load of the top value)
    PCWrite = 1'b1; pc_next = 32'hFFFFFFFC;
    tick();
    PCWrite = 1'b0;
    chk("pc_top", pc, 32'hFFFFFFFC);

    tick();
    chk("addr_q_empty", exp_addr_q.size(), 32'd0);
    chk("ir_q_empty", exp_ir_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
